// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, single-outstanding fetch port, small fetch
// buffer feeding ID as a valid/stall stream, with redirect flush and drop of stale responses.
module if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iport_addr,
  output logic        iport_stb,
  input  logic        iport_ack,
  input  logic        iport_err,
  input  logic [31:0] iport_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [1:0]  id_fault
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, KILL, HALT} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    pc_reg, pc_next;
  logic [31:0]    addr_reg, addr_next;
  logic           stb_reg, stb_next;
  logic [PTR_W:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] word_mem  [FIFO_DEPTH];
  logic [1:0]  fault_mem [FIFO_DEPTH];

  logic        done, fifo_full, push, pop, flush;
  logic [31:0] push_pc, push_word;
  logic [1:0]  push_fault;

  // A response only counts while our own request is on the port.
  assign done      = stb_reg & (iport_ack | iport_err);
  assign fifo_full = (count_reg == DEPTH_C);
  assign pop       = id_valid & ~id_stall;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    stb_next   = stb_reg;
    push       = 1'b0;
    push_pc    = addr_reg;
    push_word  = NOP;
    push_fault = 2'b00;
    flush      = 1'b0;

    if (redirect) begin
      flush   = 1'b1;
      pc_next = redirect_pc;
      if (stb_reg && !done) begin
        // Old request must finish on the bus before the new one may start.
        state_next = KILL;
      end else begin
        state_next = FETCH;
        stb_next   = (redirect_pc[1:0] == 2'b00);
        addr_next  = redirect_pc;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (done) begin
            stb_next = 1'b0;
            push     = 1'b1;
            if (iport_err) begin
              push_fault = 2'b01;
              state_next = HALT;
            end else begin
              push_word = iport_data;
              pc_next   = pc_reg + 32'd4;
            end
          end else if (!stb_reg && !fifo_full) begin
            if (pc_reg[1:0] != 2'b00) begin
              push       = 1'b1;
              push_pc    = pc_reg;
              push_fault = 2'b10;
              state_next = HALT;
            end else begin
              stb_next  = 1'b1;
              addr_next = pc_reg;
            end
          end
        end
        KILL: begin
          if (done) begin
            stb_next   = 1'b0;
            state_next = FETCH;
          end
        end
        HALT: begin
          stb_next = 1'b0;
        end
        default: begin
          state_next = FETCH;
          stb_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_ADDR;
      addr_reg   <= RESET_ADDR;
      stb_reg    <= 1'b0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      stb_reg   <= stb_next;
      if (flush) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (!push && pop) count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Buffer storage carries no reset; outputs are masked while the buffer is empty.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == PTR_W'(gi)) begin
        pc_mem[gi]    <= push_pc;
        word_mem[gi]  <= push_word;
        fault_mem[gi] <= push_fault;
      end
    end
  end

  assign iport_stb      = stb_reg;
  assign iport_addr     = addr_reg;
  assign id_valid       = (count_reg != '0);
  assign id_instruction = id_valid ? word_mem[rd_ptr_reg]  : 32'h0;
  assign id_pc          = id_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign id_fault       = id_valid ? fault_mem[rd_ptr_reg] : 2'b00;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: address-as-data memory with programmable wait states
// and a fault address, cycle-by-cycle checks of the fetch port and the ID stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iport_addr;
  logic        iport_stb;
  logic        iport_ack = 1'b0;
  logic        iport_err = 1'b0;
  logic [31:0] iport_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [1:0]  id_fault;

  int          checks = 0;
  int          failures = 0;
  int          acc_cnt = 0;
  int          mem_waits = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          acc_base;

  if_stage #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .iport_addr(iport_addr), .iport_stb(iport_stb),
    .iport_ack(iport_ack), .iport_err(iport_err), .iport_data(iport_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .id_valid(id_valid),
    .id_instruction(id_instruction), .id_pc(id_pc), .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  // Memory: answers after mem_waits idle cycles, data equals address.
  always @(negedge clk) begin
    if (iport_stb) begin
      if (wcnt == mem_waits) begin
        if (err_en && iport_addr == err_addr) begin
          iport_err = 1'b1; iport_ack = 1'b0;
        end else begin
          iport_ack = 1'b1; iport_err = 1'b0; iport_data = iport_addr;
        end
        wcnt = 0;
      end else begin
        iport_ack = 1'b0; iport_err = 1'b0; wcnt++;
      end
    end else begin
      iport_ack = 1'b0; iport_err = 1'b0; wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && id_valid && !id_stall) begin
      acc_cnt++;
      $display("ID accept pc=%h instr=%h fault=%b", id_pc, id_instruction, id_fault);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic stall);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_stall = stall;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n = 0;
    while (!id_valid && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, 32'(id_valid), 32'd1);
  endtask

  initial begin
    // Reset values and zero-wait streaming
    mem_waits = 0; err_en = 1'b0;
    step(); step();
    chk("rst_stb", 32'(iport_stb), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_fault", 32'(id_fault), 32'd0);
    chk("rst_instr", id_instruction, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stream_req_valid", 32'(id_valid), 32'd0);
      chk("stream_stb", 32'(iport_stb), 32'd1);
      chk("stream_addr", iport_addr, 32'(4 * k));
      step();
      chk("stream_valid", 32'(id_valid), 32'd1);
      chk("stream_pc", id_pc, 32'(4 * k));
      chk("stream_instr", id_instruction, 32'(4 * k));
    end

    // Stall from reset: two words buffered, then the port goes quiet
    do_reset(1'b1);
    acc_base = acc_cnt;
    repeat (4) step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("stall_stb_off", 32'(iport_stb), 32'd0);
    end
    chk("stall_valid", 32'(id_valid), 32'd1);
    chk("stall_pc", id_pc, 32'h0);
    chk("stall_instr", id_instruction, 32'h0);
    id_stall = 1'b0;
    step();
    chk("drain1_pc", id_pc, 32'h4);
    chk("drain1_stb_after_full_pop", 32'(iport_stb), 32'd0);
    step();
    chk("drain2_valid", 32'(id_valid), 32'd0);
    chk("drain2_stb", 32'(iport_stb), 32'd1);
    chk("drain2_addr", iport_addr, 32'h8);
    step();
    chk("drain3_pc", id_pc, 32'h8);
    chk("drain3_instr", id_instruction, 32'h8);
    chk("drain_count", 32'(acc_cnt - acc_base), 32'd2);

    // Redirect one cycle after stb rises, 3 wait states
    mem_waits = 3;
    do_reset(1'b0);
    acc_base = acc_cnt;
    step();
    chk("ws_stb_rise", 32'(iport_stb), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("kill_stb_held", 32'(iport_stb), 32'd1);
      chk("kill_addr_held", iport_addr, 32'h0);
      step();
    end
    chk("kill_done_stb", 32'(iport_stb), 32'd0);
    chk("kill_done_valid", 32'(id_valid), 32'd0);
    step();
    chk("kill_new_addr", iport_addr, 32'h100);
    wait_valid(10, "kill_new_timeout");
    chk("kill_new_pc", id_pc, 32'h100);
    chk("kill_no_stale", 32'(acc_cnt - acc_base), 32'd0);

    // Redirect in the same cycle as ack
    mem_waits = 0;
    do_reset(1'b0);
    acc_base = acc_cnt;
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("rdack_valid", 32'(id_valid), 32'd0);
    chk("rdack_stb", 32'(iport_stb), 32'd1);
    chk("rdack_addr", iport_addr, 32'h200);
    step();
    chk("rdack_pc", id_pc, 32'h200);
    chk("rdack_instr", id_instruction, 32'h200);
    chk("rdack_no_stale", 32'(acc_cnt - acc_base), 32'd0);

    // Bus fault on 0x8
    err_en = 1'b1; err_addr = 32'h8;
    do_reset(1'b0);
    repeat (6) step();
    chk("err_valid", 32'(id_valid), 32'd1);
    chk("err_pc", id_pc, 32'h8);
    chk("err_fault", 32'(id_fault), 32'd1);
    chk("err_instr", id_instruction, 32'h13);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("halt_stb", 32'(iport_stb), 32'd0);
    end
    chk("halt_valid", 32'(id_valid), 32'd0);
    err_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("resume_addr", iport_addr, 32'h40);
    chk("resume_stb", 32'(iport_stb), 32'd1);
    step();
    chk("resume_pc", id_pc, 32'h40);
    chk("resume_fault", 32'(id_fault), 32'd0);

    // Misaligned redirect target
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    chk("mis_no_stb", 32'(iport_stb), 32'd0);
    step();
    chk("mis_valid", 32'(id_valid), 32'd1);
    chk("mis_pc", id_pc, 32'h102);
    chk("mis_fault", 32'(id_fault), 32'd2);
    chk("mis_instr", id_instruction, 32'h13);
    chk("mis_stb", 32'(iport_stb), 32'd0);
    step();
    step();
    chk("mis_halt_stb", 32'(iport_stb), 32'd0);
    chk("mis_halt_valid", 32'(id_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0FFF_FFFC;
    step();
    redirect = 1'b0;
    chk("mis_restart_addr", iport_addr, 32'h0FFF_FFFC);
    step();
    chk("mis_restart_pc", id_pc, 32'h0FFF_FFFC);

    // PC wrap past the top of the address space
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", iport_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_addr1", iport_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", iport_addr, 32'h0);
    chk("wrap_stb2", 32'(iport_stb), 32'd1);
    step();
    chk("wrap_valid2", 32'(id_valid), 32'd1);
    chk("wrap_pc2", id_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
